// File: rtl/mac_row_pkg.sv
// Shared types and constants for the weight-stationary MAC row.
// Optional build macro: MAC_ROW_ZERO_SKIP_EN (zero-activation lane skipping with skip counter).
package mac_row_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      EXEC  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam int INST_LOAD  = 0;
   localparam int INST_EXEC  = 1;
   localparam int SKIP_CNT_W = 16;

endpackage

// File: rtl/mac_row_ctl_if.sv
// Bus bundle between the MAC row and its neighbours: activation/instruction in,
// psum chain in/out, per-column valid and controller status.
interface mac_row_ctl_if #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int lanes   = 2
);
   logic [bw*lanes-1:0]    in_w;
   logic [1:0]             inst_w;
   logic [psum_bw*col-1:0] in_n;
   logic [psum_bw*col-1:0] out_s;
   logic [col-1:0]         valid;
   logic                   load_done;
   logic                   busy;
   logic                   err;

   modport slave (
      input  in_w, inst_w, in_n,
      output out_s, valid, load_done, busy, err
   );

   modport master (
      output in_w, inst_w, in_n,
      input  out_s, valid, load_done, busy, err
   );
endinterface

// File: rtl/mac_col_pe.sv
// One MAC column: weight register, skewed activation/execute stage and lane dot-product.
// With MAC_ROW_ZERO_SKIP_EN, zero-activation lanes are operand-isolated and reported on skip_o.
module mac_col_pe
   import mac_row_pkg::*;
#(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int lanes   = 2,
   parameter int skip_w  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [bw*lanes-1:0] act_i,
   input  logic                exec_i,
   input  logic [psum_bw-1:0]  psum_i,
   input  logic                w_we_i,
   input  logic [bw*lanes-1:0] w_i,
   output logic [bw*lanes-1:0] act_o,
   output logic                exec_o,
   output logic [psum_bw-1:0]  psum_o,
   output logic                valid_o
`ifdef MAC_ROW_ZERO_SKIP_EN
   ,
   output logic [skip_w-1:0]   skip_o
`endif
);
   localparam int PW = 2*bw + 1;

   logic [bw*lanes-1:0] w_q, w_d, act_q, act_d;
   logic                exec_q, exec_d, valid_q, valid_d;
   logic [psum_bw-1:0]  psum_q, psum_d;
   logic signed [PW-1:0]      prod_s [lanes];
   logic signed [psum_bw-1:0] dot_s;
`ifdef MAC_ROW_ZERO_SKIP_EN
   logic [lanes-1:0]    zero_s;
`endif

   for (genvar l = 0; l < lanes; l++) begin : g_lane
      logic [bw-1:0]        a_s, wl_s;
      logic signed [PW-1:0] a_ext_s, w_ext_s;
`ifdef MAC_ROW_ZERO_SKIP_EN
      assign zero_s[l] = (act_i[l*bw +: bw] == {bw{1'b0}});
      assign a_s       = zero_s[l] ? {bw{1'b0}} : act_i[l*bw +: bw];
      assign wl_s      = zero_s[l] ? {bw{1'b0}} : w_q[l*bw +: bw];
`else
      assign a_s       = act_i[l*bw +: bw];
      assign wl_s      = w_q[l*bw +: bw];
`endif
      // activation is unsigned, weight is two's complement
      assign a_ext_s   = PW'($signed({1'b0, a_s}));
      assign w_ext_s   = PW'($signed(wl_s));
      assign prod_s[l] = a_ext_s * w_ext_s;
   end

   // lane sum, next-state of the column registers
   always_comb begin
      dot_s = '0;
      for (int l = 0; l < lanes; l++) begin
         dot_s = dot_s + psum_bw'(prod_s[l]);
      end
      w_d     = w_q;
      act_d   = act_i;
      exec_d  = exec_i;
      valid_d = exec_i;
      psum_d  = psum_q;
      if (w_we_i) begin
         w_d = w_i;
      end else begin
         w_d = w_q;
      end
      if (exec_i) begin
         psum_d = psum_i + dot_s;
      end else begin
         psum_d = psum_q;
      end
   end

`ifdef MAC_ROW_ZERO_SKIP_EN
   // number of lanes skipped by this column this cycle
   always_comb begin
      skip_o = '0;
      if (exec_i) begin
         for (int l = 0; l < lanes; l++) begin
            skip_o = skip_o + skip_w'(zero_s[l]);
         end
      end else begin
         skip_o = '0;
      end
   end
`endif

   // column state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_q     <= '0;
         act_q   <= '0;
         exec_q  <= 1'b0;
         valid_q <= 1'b0;
         psum_q  <= '0;
      end else begin
         w_q     <= w_d;
         act_q   <= act_d;
         exec_q  <= exec_d;
         valid_q <= valid_d;
         psum_q  <= psum_d;
      end
   end

   assign act_o   = act_q;
   assign exec_o  = exec_q;
   assign psum_o  = psum_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/mac_row_ctl.sv
// MAC row top: load/execute/drain controller, addressed weight load, sticky error, skewed columns.
// Optional build macro: MAC_ROW_ZERO_SKIP_EN adds the saturating skip_cnt output.
module mac_row_ctl
   import mac_row_pkg::*;
#(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int lanes   = 2
) (
   input  logic             clk,
   input  logic             reset,
   mac_row_ctl_if.slave     bus
`ifdef MAC_ROW_ZERO_SKIP_EN
   ,
   output logic [SKIP_CNT_W-1:0] skip_cnt
`endif
);
   localparam int CNT_W      = $clog2(col + 1);
   localparam int DRAIN_LAST = (col > 1) ? col - 2 : 0;
   localparam int SKIP_W     = $clog2(lanes + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   load_cnt_q, load_cnt_d, drain_cnt_q, drain_cnt_d;
   logic               load_done_q, load_done_d, err_q, err_d, busy_q, busy_d;
   logic [col-1:0]     w_we_s;
   logic               exec_in_s;
   logic [bw*lanes-1:0] act_chain_s [col+1];
   logic [col:0]        exec_chain_s;
   logic [psum_bw*col-1:0] out_s_s;
   logic [col-1:0]         valid_s;

   // controller next-state, weight write select and error detection
   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      drain_cnt_d = drain_cnt_q;
      load_done_d = load_done_q;
      err_d       = err_q;
      w_we_s      = '0;
      exec_in_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.inst_w == 2'b11) begin
               err_d = 1'b1;
            end else if (bus.inst_w[INST_LOAD]) begin
               state_d     = LOAD;
               w_we_s[0]   = 1'b1;
               load_cnt_d  = CNT_W'(1);
               load_done_d = (col == 1);
            end else if (bus.inst_w[INST_EXEC]) begin
               state_d   = EXEC;
               exec_in_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (bus.inst_w[INST_EXEC]) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            if (!bus.inst_w[INST_LOAD]) begin
               state_d = IDLE;
            end else if (load_done_q) begin
               err_d = 1'b1;
            end else begin
               for (int c = 0; c < col; c++) begin
                  w_we_s[c] = (load_cnt_q == CNT_W'(c));
               end
               load_cnt_d  = load_cnt_q + CNT_W'(1);
               load_done_d = (load_cnt_q == CNT_W'(col - 1));
            end
         end
         EXEC: begin
            if (bus.inst_w[INST_LOAD]) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            if (bus.inst_w[INST_EXEC]) begin
               exec_in_s = 1'b1;
            end else if (col == 1) begin
               state_d = IDLE;
            end else begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            // a fresh execute request is accepted in the same cycle, no bubble
            if (bus.inst_w[INST_EXEC]) begin
               state_d   = EXEC;
               exec_in_s = 1'b1;
            end else if (drain_cnt_q == CNT_W'(DRAIN_LAST)) begin
               state_d = IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // controller registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         load_cnt_q  <= '0;
         drain_cnt_q <= '0;
         load_done_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         load_done_q <= load_done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign act_chain_s[0] = bus.in_w;
   assign exec_chain_s[0] = exec_in_s;

`ifdef MAC_ROW_ZERO_SKIP_EN
   logic [SKIP_W-1:0]   skip_col_s [col];
   logic [SKIP_CNT_W:0] skip_sum_s;
   logic [SKIP_CNT_W-1:0] skip_cnt_q, skip_cnt_d;
`endif

   for (genvar c = 0; c < col; c++) begin : g_col
      mac_col_pe #(
         .bw(bw), .psum_bw(psum_bw), .lanes(lanes), .skip_w(SKIP_W)
      ) u_pe (
         .clk     (clk),
         .reset   (reset),
         .act_i   (act_chain_s[c]),
         .exec_i  (exec_chain_s[c]),
         .psum_i  (bus.in_n[c*psum_bw +: psum_bw]),
         .w_we_i  (w_we_s[c]),
         .w_i     (bus.in_w),
         .act_o   (act_chain_s[c+1]),
         .exec_o  (exec_chain_s[c+1]),
         .psum_o  (out_s_s[c*psum_bw +: psum_bw]),
         .valid_o (valid_s[c])
`ifdef MAC_ROW_ZERO_SKIP_EN
         ,
         .skip_o  (skip_col_s[c])
`endif
      );
   end

`ifdef MAC_ROW_ZERO_SKIP_EN
   // saturating accumulation of skipped lane-operations over all columns
   always_comb begin
      skip_sum_s = {1'b0, skip_cnt_q};
      for (int c = 0; c < col; c++) begin
         skip_sum_s = skip_sum_s + (SKIP_CNT_W+1)'(skip_col_s[c]);
      end
      if (skip_sum_s[SKIP_CNT_W]) begin
         skip_cnt_d = {SKIP_CNT_W{1'b1}};
      end else begin
         skip_cnt_d = skip_sum_s[SKIP_CNT_W-1:0];
      end
   end

   // skip counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skip_cnt_q <= '0;
      end else begin
         skip_cnt_q <= skip_cnt_d;
      end
   end

   assign skip_cnt = skip_cnt_q;
`endif

   assign bus.out_s     = out_s_s;
   assign bus.valid     = valid_s;
   assign bus.load_done = load_done_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_mac_row_ctl.sv
// Scoreboard bench for mac_row_ctl: expected psums are queued per column at issue time
// from an arithmetic reference model; a negedge monitor pops them on each valid.
module tb_mac_row_ctl;
   localparam int BW = 4, PSUM_BW = 16, COL = 8, LANES = 2, WW = BW*LANES;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_row_ctl_if #(.bw(BW), .psum_bw(PSUM_BW), .col(COL), .lanes(LANES)) bus ();
`ifdef MAC_ROW_ZERO_SKIP_EN
   logic [15:0] skip_cnt;
`endif

   mac_row_ctl #(.bw(BW), .psum_bw(PSUM_BW), .col(COL), .lanes(LANES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
`ifdef MAC_ROW_ZERO_SKIP_EN
      ,
      .skip_cnt (skip_cnt)
`endif
   );

   typedef struct { int cyc; logic [PSUM_BW-1:0] val; } exp_t;
   exp_t q_exp [COL][$];
   logic [WW-1:0] w_m [COL];
   logic [PSUM_BW*COL-1:0] n_m;

   assign bus.in_n = n_m;

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // reference: in_n + sum(unsigned act * signed weight), modulo 2^16
   function automatic logic [PSUM_BW-1:0] mac_ref(input int c, input logic [WW-1:0] act);
      int s;
      s = int'(n_m[c*PSUM_BW +: PSUM_BW]);
      for (int l = 0; l < LANES; l++) begin
         s += int'(act[l*BW +: BW]) * int'($signed(w_m[c][l*BW +: BW]));
      end
      return PSUM_BW'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      for (int c = 0; c < COL; c++) begin
         q_exp[c].delete();
         w_m[c] = '0;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      bus.inst_w = 2'b00;
      bus.in_w = '0;
      flush();
      repeat (n) tick();
      reset = 1'b1;
   endtask

   task automatic exec_word(input logic [1:0] inst, input logic [WW-1:0] act);
      exp_t e;
      bus.inst_w = inst;
      bus.in_w = act;
      for (int c = 0; c < COL; c++) begin
         e.cyc = cyc + 1 + c;
         e.val = mac_ref(c, act);
         q_exp[c].push_back(e);
      end
      tick();
   endtask

   task automatic drop_and_drain();
      bus.inst_w = 2'b00;
      repeat (COL - 1) tick();
      check("busy_before_end", bus.busy, 1);
      tick();
      check("busy_fall", bus.busy, 0);
   endtask

   task automatic load_words(input logic [WW-1:0] wv [COL]);
      for (int i = 0; i < COL; i++) begin
         bus.inst_w = 2'b01;
         bus.in_w = wv[i];
         w_m[i] = wv[i];
         tick();
         check("load_done", bus.load_done, (i == COL - 1));
      end
   endtask

   task automatic idle();
      bus.inst_w = 2'b00;
      tick();
   endtask

   task automatic rand_in_n();
      for (int c = 0; c < COL; c++) n_m[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
   endtask

   // monitor: every asserted valid must match the oldest expectation for that column
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         for (int c = 0; c < COL; c++) begin
            if (bus.valid[c] === 1'b1) begin
               if (q_exp[c].size() == 0) begin
                  check($sformatf("unexpected_valid_col%0d", c), 1, 0);
               end else begin
                  exp_t e;
                  e = q_exp[c].pop_front();
                  check($sformatf("valid_cycle_col%0d", c), cyc, e.cyc);
                  check($sformatf("out_s_col%0d", c), bus.out_s[c*PSUM_BW +: PSUM_BW], e.val);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WW-1:0] wv [COL];
      bit found;
      logic [15:0] skip0;
      n_m = '0;
      bus.in_w = '0;
      bus.inst_w = 2'b00;
      reset = 1'b0;

      // reset values
      do_reset(3);
      check("rst_out_s", bus.out_s, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_err", bus.err, 0);
      check("rst_load_done", bus.load_done, 0);
`ifdef MAC_ROW_ZERO_SKIP_EN
      check("rst_skip_cnt", skip_cnt, 0);
`endif

      // load 0x11..0x88, single activation 0x21
      for (int i = 0; i < COL; i++) wv[i] = WW'(8'h11 * (i + 1));
      load_words(wv);
      check("busy_load", bus.busy, 1);
      idle();
      check("busy_idle", bus.busy, 0);
      n_m = '0;
      exec_word(2'b10, 8'h21);
      drop_and_drain();
      check("col0_dot", bus.out_s[15:0], 16'd3);

      // signed weights and wrap
      for (int i = 0; i < COL; i++) wv[i] = WW'($urandom);
      wv[0] = 8'h88;
      load_words(wv);
      idle();
      exec_word(2'b10, 8'hFF);
      drop_and_drain();
      check("signed_neg", bus.out_s[15:0], 16'hFF10);
      n_m[15:0] = 16'h8000;
      exec_word(2'b10, 8'hFF);
      drop_and_drain();
      check("signed_wrap", bus.out_s[15:0], 16'h7F10);

      // back-to-back: burst, 2-cycle drop, re-enter from DRAIN
      rand_in_n();
      for (int i = 0; i < 5; i++) exec_word(2'b10, WW'($urandom));
      idle();
      idle();
      check("busy_in_drain", bus.busy, 1);
      for (int i = 0; i < 3; i++) exec_word(2'b10, WW'($urandom));
      drop_and_drain();

      // error: 9th load beat leaves weights intact
      do_reset(2);
      for (int i = 0; i < COL; i++) wv[i] = WW'($urandom);
      load_words(wv);
      check("err_pre9", bus.err, 0);
      bus.inst_w = 2'b01;
      bus.in_w = ~wv[0];
      tick();
      check("err_9th", bus.err, 1);
      idle();
      rand_in_n();
      for (int i = 0; i < 3; i++) exec_word(2'b10, WW'($urandom));
      drop_and_drain();
      check("err_sticky9", bus.err, 1);

      // error: 11 in IDLE
      do_reset(2);
      check("err_clr", bus.err, 0);
      bus.inst_w = 2'b11;
      tick();
      check("err_idle11", bus.err, 1);
      check("busy_idle11", bus.busy, 0);
      idle();
      idle();
      check("err_sticky11", bus.err, 1);

      // error: load bit during EXEC (execution continues)
      do_reset(2);
      rand_in_n();
      exec_word(2'b10, WW'($urandom));
      check("err_pre_exec", bus.err, 0);
      exec_word(2'b11, WW'($urandom));
      check("err_exec", bus.err, 1);
      drop_and_drain();
      check("err_sticky_exec", bus.err, 1);

      // reset mid-EXEC, then execute with zero weights
      do_reset(2);
      for (int i = 0; i < COL; i++) wv[i] = WW'($urandom);
      load_words(wv);
      idle();
      rand_in_n();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         exec_word(2'b10, WW'($urandom));
         if (bus.valid[3] === 1'b1) found = 1'b1;
      end
      check("valid3_seen", found, 1);
      #2;
      reset = 1'b0;
      flush();
      bus.inst_w = 2'b00;
      #1;
      check("async_out_s", bus.out_s, 0);
      check("async_valid", bus.valid, 0);
      check("async_busy", bus.busy, 0);
      check("async_load_done", bus.load_done, 0);
      tick();
      tick();
      reset = 1'b1;
      rand_in_n();
      for (int i = 0; i < 3; i++) exec_word(2'b10, WW'($urandom));
      drop_and_drain();

`ifdef MAC_ROW_ZERO_SKIP_EN
      // zero activations: 4 words x 8 columns x 2 lanes skipped
      skip0 = skip_cnt;
      for (int i = 0; i < 4; i++) exec_word(2'b10, 8'h00);
      drop_and_drain();
      check("skip_cnt", skip_cnt - skip0, 16'd64);
`else
      skip0 = 16'd0;
`endif

      // randomized load/execute rounds
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < COL; i++) wv[i] = WW'($urandom);
         load_words(wv);
         idle();
         rand_in_n();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) exec_word(2'b10, WW'($urandom));
         drop_and_drain();
      end

      tick();
      for (int c = 0; c < COL; c++) check($sformatf("queue_empty_col%0d", c), q_exp[c].size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mac_row_ctl.md
Name: mac_row_ctl

Overview:
Parametrised successor MAC row for the weight-stationary array. It holds `col` columns, each `lanes` wide, and adds the following over the previous row generation:
- a load/execute/drain controller FSM
- addressed (non-shifting) weight load with a load-complete flag
- a sticky protocol-error flag
- a per-column output valid that follows a one-column-per-cycle activation skew

The block sits between the L0 activation FIFO (west) and the psum/OFIFO path (north/south).

Parameters:
- bw, 4, activation/weight element width
- psum_bw, 16, partial-sum width
- col, 8, number of MAC columns
- lanes, 2, elements packed per in_w word (dot-product length per column per cycle)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- in_w  input  bw*lanes  activation word (EXEC) or weight word (LOAD); lane l = bits [bw*(l+1)-1 : bw*l]
- inst_w  input  2  [1]=execute, [0]=kernel load
- in_n  input  psum_bw*col  incoming psums, column c at [psum_bw*(c+1)-1 : psum_bw*c]
- out_s  output  psum_bw*col  outgoing psums, same packing
- valid  output  col  per-column out_s valid
- load_done  output  1  all `col` weight words loaded
- busy  output  1  FSM not IDLE
- err  output  1  sticky protocol error

Behaviour:
- Reset (reset=0, async) clears all of the following to 0 and sets FSM=IDLE:
  - out_s, valid, load_done, busy, err
  - weight registers, activation pipeline registers, execute pipeline bits, load_cnt
- FSM states: IDLE, LOAD, EXEC, DRAIN.
  - IDLE: inst_w=01 -> LOAD with load_cnt=0 (load_done cleared), and this cycle's in_w is written to column 0. inst_w=10 -> EXEC. inst_w=11 -> set err, stay IDLE.
  - LOAD: each cycle with inst_w[0]=1, column load_cnt latches in_w and load_cnt increments. When load_cnt reaches col-1 and is written, load_done=1 next cycle. load_done holds until the next LOAD entry.
  - LOAD exit: inst_w[0]=0 returns to IDLE. A load beat after load_done=1 is ignored and sets err. inst_w[1]=1 in LOAD sets err and is ignored.
  - EXEC: while inst_w[1]=1, the activation pipeline is fed from in_w. When inst_w[1] falls, go to DRAIN. inst_w[0]=1 in EXEC sets err and is ignored.
  - DRAIN: counter runs col cycles so the execute bit propagates out of the last column, then IDLE. A new inst_w[1]=1 during DRAIN re-enters EXEC with no bubble.
- EXEC with load_done=0 is allowed and uses the current weights (zeros after reset). No err is raised.
- busy=1 in LOAD/EXEC/DRAIN.
- Skew: column c registers the activation word and execute bit from column c-1 (column 0 from in_w/inst_w[1]). An activation presented at cycle t reaches column c at edge t+c+1.
- Column c output, at edge t+c+1 when its execute bit is 1:
  - out_s[c] <= in_n[c] + sum over l of (zero-extended unsigned act_l) * (sign-extended signed w_l)
  - product width is 2*bw+1; sum is sign-extended to psum_bw and wraps modulo 2^psum_bw (no saturation)
  - valid[c] <= 1
- When a column's execute bit is 0: valid[c] <= 0 and out_s[c] holds its last value.
- in_n[c] is sampled on the same edge as column c's activation.
- Reset mid-operation aborts immediately. Weights are lost; load_done=0.
- err clears only on reset.

Optional Feature:
- Macro: MAC_ROW_ZERO_SKIP_EN.
- Defined:
  - any lane with activation 0 bypasses its multiplier (operand-isolated; contributes 0)
  - extra output port skip_cnt (16 bit) counts skipped lane-operations across all columns in EXEC/DRAIN, saturating at 16'hFFFF, cleared by reset
  - out_s results are bit-identical to the non-skip build
- Undefined: no skip_cnt port; all lanes always multiply.

Decomposition:
- Package mac_row_pkg holds:
  - FSM state enum (IDLE=2'd0, LOAD=2'd1, EXEC=2'd2, DRAIN=2'd3)
  - inst_w bit-index constants (INST_LOAD=0, INST_EXEC=1)
  - SKIP_CNT_W=16
- One sub-module, mac_col_pe: a single column with weight register, activation/execute pipeline stage and lane dot-product. It is instantiated `col` times in a generate loop. The FSM, load_cnt and err live in the top.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> out_s=0, valid=0, busy=0, err=0, load_done=0.
- Load 8 words 0x11..0x88 -> load_done=1 on the cycle after the 8th beat. Then EXEC one word act=0x21 (lanes 1,2) with in_n=0 -> each column c's valid pulses exactly at t+c+1. For column 0 with weights (1,1): out_s[0]=3.
- Signed wrap: weights 0x88 (-8,-8), act 0xFF (15,15), in_n[0]=16'h0000 -> out_s[0]=16'hFF10 (-240). Then in_n[0]=16'h8000 -> out_s[0]=16'h7F10 (wrap).
- Back-to-back EXEC: 5-cycle execute burst, drop for 2 cycles (DRAIN), reassert -> FSM goes DRAIN->EXEC with no gap in column-0 valid. busy falls exactly col cycles after the final drop.
- Errors: inst_w=11 in IDLE, a 9th load beat, and inst_w[0]=1 during EXEC -> each independently sets err=1, which stays set. Weights are unchanged by the 9th beat.
- Reset mid-EXEC: assert reset with valid[3]=1 -> all outputs 0 asynchronously. After release, EXEC with no reload yields out_s=in_n.
- MAC_ROW_ZERO_SKIP_EN build: 4-cycle burst of act=0x00 -> skip_cnt=64 (4×8×2). out_s matches the non-skip build.
